btb_port_ctrl: RTL and testbench

//  Sequencer/arbiter for a single-port, synchronous-read BTB RAM (1-cycle read latency).

---
 rtl/btb_port_if.sv | 39 +++
 rtl/btb_port_ctrl.sv | 173 +++++++++++++++++
 tb/tb_btb_port_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/btb_port_if.sv
// Bundle of lookup, update, flush and RAM-port signals shared by the BTB port controller
// and the logic around it.
interface btb_port_if #(
  parameter int IDX_W = 7
);
  localparam int TAG_W = 30 - IDX_W;
  localparam int ENT_W = 1 + TAG_W + 32 + 2;

  logic             lk_valid;
  logic [31:0]      lk_pc;
  logic             lk_ready;
  logic             rsp_valid;
  logic             rsp_taken;
  logic [31:0]      rsp_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_target;
  logic             upd_taken;
  logic             upd_ready;
  logic             flush_req;
  logic             flush_busy;
  logic             ram_en;
  logic             ram_we;
  logic [IDX_W-1:0] ram_addr;
  logic [ENT_W-1:0] ram_wdata;
  logic [ENT_W-1:0] ram_rdata;

  modport slave (
    input  lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req, ram_rdata,
    output lk_ready, rsp_valid, rsp_taken, rsp_target, upd_ready, flush_busy,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output lk_valid, lk_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req, ram_rdata,
    input  lk_ready, rsp_valid, rsp_taken, rsp_target, upd_ready, flush_busy,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/btb_port_ctrl.sv
// Single-port BTB RAM sequencer: IF lookups, queued read-modify-write counter updates,
// and a whole-table invalidate after reset or on request.
//  state | meaning
//  IDLE  | serve lookups, pick next update or flush
//  U_RD  | read entry at FIFO head index
//  U_WR  | update/allocate entry from read data, pop FIFO
//  FLUSH | write zero entries, one index per cycle
module btb_port_ctrl #(
  parameter int IDX_W  = 7,
  parameter int QDEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  btb_port_if.slave bus
);
  localparam int TAG_W = 30 - IDX_W;
  localparam int ENT_W = 1 + TAG_W + 32 + 2;
  localparam int QA_W  = $clog2(QDEPTH);
  localparam logic [QA_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, U_RD, U_WR, FLUSH} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_flush_cnt;
  logic             r_flush_pend;
  logic [QA_W:0]    r_wr_ptr;
  logic [QA_W:0]    r_rd_ptr;
  logic             r_rsp_pend;
  logic [TAG_W-1:0] r_lk_tag;
  logic [31:0]      r_q_pc  [QDEPTH];
  logic [31:0]      r_q_tgt [QDEPTH];
  logic             r_q_tk  [QDEPTH];

  logic             w_fifo_full, w_fifo_empty, w_flush_any, w_lk_ready, w_lk_acc, w_push;
  logic [31:0]      w_head_pc, w_head_tgt;
  logic             w_head_tk;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_tgt;
  logic [1:0]       w_rd_ctr, w_ctr_inc, w_ctr_dec;
  logic             w_upd_hit, w_lk_hit;
  logic             w_ram_en, w_ram_we;
  logic [IDX_W-1:0] w_ram_addr;
  logic [ENT_W-1:0] w_ram_wdata;
  logic             w_unused_pc_lsb;

  assign w_fifo_full  = (r_wr_ptr[QA_W] != r_rd_ptr[QA_W]) &&
                        (r_wr_ptr[QA_W-1:0] == r_rd_ptr[QA_W-1:0]);
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  // A flush held over from an update sequence also blocks lookups, so none is accepted unserved.
  assign w_flush_any  = bus.flush_req | r_flush_pend;
  assign w_lk_ready   = (r_state == IDLE) & ~w_flush_any & ~w_fifo_full;
  assign w_lk_acc     = w_lk_ready & bus.lk_valid;
  assign w_push       = bus.upd_valid & ~w_fifo_full;

  assign w_head_pc  = r_q_pc[r_rd_ptr[QA_W-1:0]];
  assign w_head_tgt = r_q_tgt[r_rd_ptr[QA_W-1:0]];
  assign w_head_tk  = r_q_tk[r_rd_ptr[QA_W-1:0]];
  assign w_unused_pc_lsb = ^{w_head_pc[1:0], bus.lk_pc[1:0]};

  assign w_rd_valid = bus.ram_rdata[ENT_W-1];
  assign w_rd_tag   = bus.ram_rdata[ENT_W-2 -: TAG_W];
  assign w_rd_tgt   = bus.ram_rdata[33:2];
  assign w_rd_ctr   = bus.ram_rdata[1:0];
  assign w_ctr_inc  = (w_rd_ctr == 2'b11) ? 2'b11 : w_rd_ctr + 2'd1;
  assign w_ctr_dec  = (w_rd_ctr == 2'b00) ? 2'b00 : w_rd_ctr - 2'd1;
  assign w_upd_hit  = w_rd_valid & (w_rd_tag == w_head_pc[31:IDX_W+2]);
  // Read data is only meaningful on the cycle after an accepted lookup.
  assign w_lk_hit   = r_rsp_pend & w_rd_valid & (w_rd_tag == r_lk_tag) & w_rd_ctr[1];

  assign bus.lk_ready   = w_lk_ready;
  assign bus.upd_ready  = ~w_fifo_full;
  assign bus.flush_busy = (r_state == FLUSH);
  assign bus.rsp_valid  = r_rsp_pend;
  assign bus.rsp_taken  = w_lk_hit;
  assign bus.rsp_target = w_lk_hit ? w_rd_tgt : 32'd0;

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    case (r_state)
      IDLE: begin
        w_ram_en   = w_lk_acc;
        w_ram_addr = bus.lk_pc[IDX_W+1:2];
      end
      U_RD: begin
        w_ram_en   = 1'b1;
        w_ram_addr = w_head_pc[IDX_W+1:2];
      end
      U_WR: begin
        w_ram_addr = w_head_pc[IDX_W+1:2];
        if (w_upd_hit) begin
          w_ram_en    = 1'b1;
          w_ram_we    = 1'b1;
          w_ram_wdata = {1'b1, w_rd_tag, w_head_tk ? w_head_tgt : w_rd_tgt,
                         w_head_tk ? w_ctr_inc : w_ctr_dec};
        end else if (w_head_tk) begin
          w_ram_en    = 1'b1;
          w_ram_we    = 1'b1;
          w_ram_wdata = {1'b1, w_head_pc[31:IDX_W+2], w_head_tgt, 2'b10};
        end
      end
      FLUSH: begin
        w_ram_en   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_flush_cnt;
      end
      default: ;
    endcase
  end

  // The reset state is FLUSH, so the port is held quiet while reset is asserted.
  assign bus.ram_en    = w_ram_en & ~rst;
  assign bus.ram_we    = w_ram_we & ~rst;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_wdata = w_ram_wdata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr[QA_W-1:0]]  <= bus.upd_pc;
      r_q_tgt[r_wr_ptr[QA_W-1:0]] <= bus.upd_target;
      r_q_tk[r_wr_ptr[QA_W-1:0]]  <= bus.upd_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= FLUSH;
      r_flush_cnt  <= '0;
      r_flush_pend <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_rsp_pend   <= 1'b0;
      r_lk_tag     <= '0;
    end else begin
      r_rsp_pend <= w_lk_acc;
      if (w_lk_acc) r_lk_tag <= bus.lk_pc[31:IDX_W+2];
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (r_state == U_WR) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case (r_state)
        IDLE: begin
          if (w_flush_any) begin
            r_state      <= FLUSH;
            r_flush_cnt  <= '0;
            r_flush_pend <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
          end else if (w_fifo_full) begin
            r_state <= U_RD;
          end else if (!bus.lk_valid && !w_fifo_empty) begin
            r_state <= U_RD;
          end
        end
        U_RD: begin
          if (bus.flush_req) r_flush_pend <= 1'b1;
          r_state <= U_WR;
        end
        U_WR: begin
          if (bus.flush_req) r_flush_pend <= 1'b1;
          r_state <= IDLE;
        end
        FLUSH: begin
          if (bus.flush_req) r_flush_cnt <= '0;
          else if (&r_flush_cnt) r_state <= IDLE;
          else r_flush_cnt <= r_flush_cnt + IDX_W'(1);
        end
        default: r_state <= FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_port_ctrl.sv
// Directed bench for btb_port_ctrl with an 8-entry table and a behavioural 1-cycle RAM.
module tb_btb_port_ctrl;
  localparam int IDX_W = 3;
  localparam int ENT_W = 62;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  btb_port_if #(.IDX_W(IDX_W)) bus ();
  btb_port_ctrl #(.IDX_W(IDX_W), .QDEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [ENT_W-1:0] mem [8];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                      input logic [31:0] exp_tgt);
    step();
    bus.lk_valid = 1'b1;
    bus.lk_pc    = pc;
    #1;
    chk({tag, "_lk_ready"}, bus.lk_ready, 1'b1);
    step();
    bus.lk_valid = 1'b0;
    #1;
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
    chk({tag, "_rsp_taken"}, bus.rsp_taken, exp_tk);
    chk({tag, "_rsp_target"}, bus.rsp_target, exp_tgt);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic [2:0] idx, input logic exp_we,
                     input logic [ENT_W-1:0] exp_wd);
    step();
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tk;
    #1;
    chk({tag, "_upd_ready"}, bus.upd_ready, 1'b1);
    step();
    bus.upd_valid = 1'b0;
    step();
    chk({tag, "_rd_en"}, {bus.ram_en, bus.ram_we}, 2'b10);
    chk({tag, "_rd_addr"}, bus.ram_addr, idx);
    step();
    chk({tag, "_wr_en"}, {bus.ram_en, bus.ram_we}, {exp_we, exp_we});
    if (exp_we) chk({tag, "_wdata"}, bus.ram_wdata, exp_wd);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lk_valid   = 1'b0;
    bus.lk_pc      = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.flush_req  = 1'b0;

    repeat (3) @(posedge clk);
    step();
    chk("rst_flush_busy", bus.flush_busy, 1'b1);
    chk("rst_lk_ready", bus.lk_ready, 1'b0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_taken, bus.rsp_target}, 34'd0);
    chk("rst_upd_ready", bus.upd_ready, 1'b1);
    chk("rst_ram_en_we", {bus.ram_en, bus.ram_we}, 2'b00);

    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("init_busy", bus.flush_busy, 1'b1);
      chk("init_we", {bus.ram_en, bus.ram_we}, 2'b11);
      chk("init_addr", bus.ram_addr, i[2:0]);
      chk("init_wdata", bus.ram_wdata, 62'd0);
      step();
    end
    chk("init_done_busy", bus.flush_busy, 1'b0);
    chk("init_done_lk_ready", bus.lk_ready, 1'b1);

    look("empty", 32'h100, 1'b0, 32'h0);
    step();
    chk("single_rsp_pulse", bus.rsp_valid, 1'b0);

    upd("alloc", 32'h100, 32'h200, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h200, 2'b10});
    look("hit_taken", 32'h100, 1'b1, 32'h200);
    upd("dec1", 32'h100, 32'h999, 1'b0, 3'd0, 1'b1, {1'b1, 27'd8, 32'h200, 2'b01});
    upd("dec2", 32'h100, 32'h999, 1'b0, 3'd0, 1'b1, {1'b1, 27'd8, 32'h200, 2'b00});
    look("weak_nt", 32'h100, 1'b0, 32'h0);
    upd("dec_sat", 32'h100, 32'h999, 1'b0, 3'd0, 1'b1, {1'b1, 27'd8, 32'h200, 2'b00});
    upd("inc1", 32'h100, 32'h300, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h300, 2'b01});
    upd("inc2", 32'h100, 32'h300, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h300, 2'b10});
    upd("inc3", 32'h100, 32'h300, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h300, 2'b11});
    upd("inc_sat", 32'h100, 32'h300, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h300, 2'b11});
    look("retarget", 32'h100, 1'b1, 32'h300);
    look("alias_miss", 32'h120, 1'b0, 32'h0);
    upd("alias_nt", 32'h120, 32'h400, 1'b0, 3'd0, 1'b0, '0);
    look("alias_kept", 32'h100, 1'b1, 32'h300);

    // Fill the FIFO while lookups hold the port.
    step();
    bus.lk_valid   = 1'b1;
    bus.lk_pc      = 32'h100;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h4;
    bus.upd_target = 32'h0;
    bus.upd_taken  = 1'b0;
    step();
    step();
    chk("b2b_rsp_valid", bus.rsp_valid, 1'b1);
    step();
    step();
    chk("full_upd_ready", bus.upd_ready, 1'b0);
    chk("full_lk_ready", bus.lk_ready, 1'b0);
    step();
    chk("full_urd_lk_ready", bus.lk_ready, 1'b0);
    chk("full_urd_addr", bus.ram_addr, 3'd1);
    chk("full_urd_rsp", bus.rsp_valid, 1'b0);
    step();
    chk("full_uwr_upd_ready", bus.upd_ready, 1'b0);
    chk("full_uwr_no_write", bus.ram_en, 1'b0);
    step();
    chk("popped_lk_ready", bus.lk_ready, 1'b1);
    chk("popped_upd_ready", bus.upd_ready, 1'b1);
    bus.lk_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    repeat (10) step();
    chk("drained_ram_en", bus.ram_en, 1'b0);

    // Flush arriving while an update write is in flight.
    step();
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h8;
    bus.upd_target = 32'h500;
    bus.upd_taken  = 1'b1;
    step();
    bus.upd_pc     = 32'h100;
    bus.upd_target = 32'h600;
    step();
    bus.upd_valid = 1'b0;
    chk("fl_urd_addr", bus.ram_addr, 3'd2);
    step();
    bus.flush_req = 1'b1;
    #1;
    chk("fl_uwr_we", {bus.ram_en, bus.ram_we}, 2'b11);
    chk("fl_uwr_wdata", bus.ram_wdata, {1'b1, 27'd0, 32'h500, 2'b10});
    step();
    bus.flush_req = 1'b0;
    #1;
    chk("fl_pend_busy", bus.flush_busy, 1'b0);
    chk("fl_pend_lk_ready", bus.lk_ready, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("fl_busy", bus.flush_busy, 1'b1);
      chk("fl_addr", bus.ram_addr, i[2:0]);
      step();
    end
    chk("fl_done_busy", bus.flush_busy, 1'b0);
    step();
    chk("fl_dropped_upd", bus.ram_en, 1'b0);
    look("fl_miss_a", 32'h8, 1'b0, 32'h0);
    look("fl_miss_b", 32'h100, 1'b0, 32'h0);

    // Async reset right after a lookup is accepted.
    upd("pre_rst", 32'h100, 32'h700, 1'b1, 3'd0, 1'b1, {1'b1, 27'd8, 32'h700, 2'b10});
    step();
    bus.lk_valid = 1'b1;
    bus.lk_pc    = 32'h100;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.lk_valid = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_busy", bus.flush_busy, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_restart_addr", bus.ram_addr, 3'd0);
    chk("arst_restart_we", {bus.ram_en, bus.ram_we}, 2'b11);
    chk("arst_no_rsp", bus.rsp_valid, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("arst_fl_addr", bus.ram_addr, i[2:0]);
    end
    step();
    chk("arst_done_busy", bus.flush_busy, 1'b0);
    look("arst_miss", 32'h100, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
